// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius player-side checker.
// Holds the checker state enum, default step width and colour codes.
package genius_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2
    } checker_state_t;

    localparam int SEQ_W_DEFAULT = 4;

    localparam logic [3:0] COR_0 = 4'b0001;
    localparam logic [3:0] COR_1 = 4'b0010;
    localparam logic [3:0] COR_2 = 4'b0100;
    localparam logic [3:0] COR_3 = 4'b1000;

endpackage

// File: rtl/genius_timeout_timer.sv
// Idle-cycle timer for the Genius input checker.
// Ports: clk_i, rst_i, clear_i, enable_i in; expired_o out (registered),
// high in the cycle the count holds TIMEOUT_CYCLES-1.
module genius_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic             expired_q;

    // expired_q is raised one edge early so it lines up with the
    // cycle in which count_q equals TIMEOUT_CYCLES-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (clear_i) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (enable_i) begin
            count_q   <= count_q + CNT_W'(1);
            expired_q <= (count_q == CNT_W'(TIMEOUT_CYCLES - 2));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/genius_input_checker.sv
// Player-side sequence checker: walks the ROM address per press/release.
// Ports: clock, reset, start, round_len, botoes, esperado in;
// address, acerto, erro, ocupado out.
module genius_input_checker
    import genius_pkg::*;
#(
    parameter int SEQ_W          = SEQ_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SEQ_W-1:0] round_len,
    input  logic [3:0]       botoes,
    input  logic [3:0]       esperado,
    output logic [SEQ_W-1:0] address,
    output logic             acerto,
    output logic             erro,
    output logic             ocupado
);

    checker_state_t   state_q, state_d;
    logic [SEQ_W-1:0] addr_q, addr_d;
    logic [SEQ_W-1:0] len_q, len_d;
    logic [3:0]       held_q, held_d;
    logic             acerto_q, acerto_d;
    logic             erro_q, erro_d;
    logic             tmr_clear;
    logic             tmr_en;
    logic             tmr_expired;

    genius_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clock),
        .rst_i    (reset),
        .clear_i  (tmr_clear),
        .enable_i (tmr_en),
        .expired_o(tmr_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            held_q   <= '0;
            acerto_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            held_q   <= held_d;
            acerto_q <= acerto_d;
            erro_q   <= erro_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        held_d    = held_q;
        acerto_d  = 1'b0;
        erro_d    = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Keeps the timer at zero so WAIT_PRESS starts fresh.
                tmr_clear = 1'b1;
                if (start) begin
                    len_d   = round_len;
                    addr_d  = '0;
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                // A press wins over a timeout sampled in the same cycle.
                if (botoes == 4'b0000) begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        erro_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (botoes == esperado) begin
                    held_d  = botoes;
                    state_d = WAIT_RELEASE;
                end else begin
                    erro_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_RELEASE: begin
                if ((botoes & ~held_q) != 4'b0000) begin
                    erro_d  = 1'b1;
                    state_d = IDLE;
                end else if (botoes == 4'b0000) begin
                    if (addr_q == len_q) begin
                        acerto_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        addr_d    = addr_q + SEQ_W'(1);
                        tmr_clear = 1'b1;
                        state_d   = WAIT_PRESS;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign address = addr_q;
    assign acerto  = acerto_q;
    assign erro    = erro_q;
    assign ocupado = (state_q != IDLE);

endmodule
